// File: rtl/legv8_pkg.sv
// Shared definitions for the multi-cycle LEGv8 control path: opcodes,
// ALUOp / mux select encodings, opcode classes and the FSM state set.
package legv8_pkg;

    // Full 11-bit opcodes (inst[31:21])
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Short-opcode formats are matched on their prefix only
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

    // ALUOp driven into the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // PC source mux
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_BTGT   = 2'd2;

    // ALU B-operand mux
    localparam logic [1:0] ALUB_REG     = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_WB_R      = 4'd3,
        ST_ADDR      = 4'd4,
        ST_MEM_RD    = 4'd5,
        ST_WB_MEM    = 4'd6,
        ST_MEM_WR    = 4'd7,
        ST_BRANCH_CB = 4'd8,
        ST_BRANCH_U  = 4'd9,
        ST_TRAP      = 4'd10
    } state_t;

endpackage

// File: rtl/legv8_opcode_class.sv
// Combinational opcode -> instruction class decode. Full-opcode matches are
// checked before the short-prefix formats so the first match wins.
module legv8_opcode_class
    import legv8_pkg::*;
(
    input  logic [10:0] i_opcode,
    output op_class_t   o_class
);

    // Priority decode of the opcode field
    always_comb begin
        o_class = CLS_ILLEGAL;
        if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
            i_opcode == OP_AND || i_opcode == OP_ORR) begin
            o_class = CLS_RTYPE;
        end else if (i_opcode == OP_LDUR) begin
            o_class = CLS_LOAD;
        end else if (i_opcode == OP_STUR) begin
            o_class = CLS_STORE;
        end else if (i_opcode[10:3] == OP_CBZ_PFX) begin
            o_class = CLS_CBZ;
        end else if (i_opcode[10:5] == OP_B_PFX) begin
            o_class = CLS_B;
        end
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multi-cycle LEGv8 datapath, with retired-
// instruction counter and sticky illegal-opcode flag.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   FETCH        | read IR from memory at PC, PC <= PC+4 on mem_ready
//   DECODE       | classify opcode, ALUOut <= PC + (imm<<2)
//   EXEC_R       | R-type ALU operation on A, B
//   WB_R         | write ALUOut to Rd, retire
//   ADDR         | effective address A + sign-ext imm
//   MEM_RD       | load access, held until mem_ready
//   WB_MEM       | write MDR to Rt, retire
//   MEM_WR       | store access, retire on mem_ready
//   BRANCH_CB    | CBZ: PC <= ALUOut when zero, retire
//   BRANCH_U     | B: PC <= branch target, retire
//   TRAP         | unknown opcode, parked until reset
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OPC_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg2loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           r_state;
    state_t           w_next;
    op_class_t        w_class;
    logic             w_retire;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    // The zero flag gates pc_write_cond inside the datapath; it is carried
    // through this block only so the port list matches the datapath wiring.
    logic w_zero_unused;
    assign w_zero_unused = zero;

    legv8_opcode_class u_opcode_class (
        .i_opcode (opcode[10:0]),
        .o_class  (w_class)
    );

    // Next-state and per-cycle datapath enables; everything held 0 in reset
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALUOP_ADD;
        reg2loc       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = ALUB_IMM_SH2;
                    reg2loc   = (w_class == CLS_STORE) || (w_class == CLS_CBZ);
                    case (w_class)
                        CLS_RTYPE: w_next = ST_EXEC_R;
                        CLS_LOAD,
                        CLS_STORE: w_next = ST_ADDR;
                        CLS_CBZ:   w_next = ST_BRANCH_CB;
                        CLS_B:     w_next = ST_BRANCH_U;
                        default:   w_next = ST_TRAP;
                    endcase
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_REG;
                    alu_op    = ALUOP_RTYPE;
                    w_next    = ST_WB_R;
                end
                ST_WB_R: begin
                    reg_write = 1'b1;
                    w_retire  = 1'b1;
                    w_next    = ST_FETCH;
                end
                ST_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                    w_next    = (w_class == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        w_next = ST_WB_MEM;
                    end
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = ST_FETCH;
                end
                ST_MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    reg2loc   = 1'b1;
                    if (mem_ready) begin
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                end
                ST_BRANCH_CB: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = ALUB_REG;
                    alu_op        = ALUOP_PASSB;
                    pc_write_cond = 1'b1;
                    pc_src        = PC_SRC_ALUOUT;
                    w_retire      = 1'b1;
                    w_next        = ST_FETCH;
                end
                ST_BRANCH_U: begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_BTGT;
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
                ST_TRAP: begin
                    w_next = ST_TRAP;
                end
                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

    // State register, sticky illegal flag and wrapping retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign illegal = reset ? 1'b0 : r_illegal;
    assign retired = reset ? '0 : r_retired;
    assign state   = reset ? ST_FETCH : r_state;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: an instruction-level reference model
// (per-class step lists plus memory-wait rules) checked every cycle, with
// directed scenarios pinned by literal expectations and a randomized run.
module tb_legv8_multicycle_ctrl;
    import legv8_pkg::*;

    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [10:0]       opcode = '0;
    logic              zero = 1'b0;
    logic              mem_ready = 1'b0;
    logic              mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic              pc_write_cond, alu_src_a, reg2loc, reg_write, mem_to_reg, illegal;
    logic [1:0]        pc_src, alu_src_b, alu_op;
    logic [CNT_W-1:0]  retired;
    logic [3:0]        state;

    legv8_multicycle_ctrl #(.CNT_W(CNT_W), .OPC_W(11)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg2loc(reg2loc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    wire [16:0] dut_vec = {mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
                           pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op,
                           reg2loc, reg_write, mem_to_reg};

    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

    int          errors = 0;
    int          checks = 0;
    int          n_cyc  = 0;
    int          m_idx  = 0;
    logic [31:0] m_ret  = '0;
    logic        m_ill  = 1'b0;
    logic [10:0] cur_op = '0;

    function automatic int classify(input logic [10:0] op);
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return C_R;
            11'b11111000010:                  return C_LD;
            11'b11111000000:                  return C_ST;
            11'b10110100???:                  return C_CBZ;
            11'b000101?????:                  return C_B;
            default:                          return C_ILL;
        endcase
    endfunction

    function automatic int len_of(input int cls);
        case (cls)
            C_R:     return 4;
            C_LD:    return 5;
            C_ST:    return 4;
            default: return 3;
        endcase
    endfunction

    function automatic state_t step_of(input int cls, input int idx);
        if (idx == 0) return ST_FETCH;
        if (idx == 1) return ST_DECODE;
        case (cls)
            C_R:     return (idx == 2) ? ST_EXEC_R : ST_WB_R;
            C_LD:    return (idx == 2) ? ST_ADDR : (idx == 3) ? ST_MEM_RD : ST_WB_MEM;
            C_ST:    return (idx == 2) ? ST_ADDR : ST_MEM_WR;
            C_CBZ:   return ST_BRANCH_CB;
            C_B:     return ST_BRANCH_U;
            default: return ST_TRAP;
        endcase
    endfunction

    // Expected control vector for a step, built straight from the step's role
    function automatic logic [16:0] exp_out(input state_t st, input int cls, input logic rdy);
        logic req, rd, wr, iod, irw, pcw, pcc, asa, r2l, rw, m2r;
        logic [1:0] ps, asb, aop;
        {req, rd, wr, iod, irw, pcw, pcc, asa, r2l, rw, m2r} = '0;
        ps = 2'd0; asb = 2'd0; aop = 2'd0;
        case (st)
            ST_FETCH:     begin req = 1; rd = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            ST_DECODE:    begin asb = 2'd3; r2l = (cls == C_ST) || (cls == C_CBZ); end
            ST_EXEC_R:    begin asa = 1; aop = 2'd2; end
            ST_WB_R:      begin rw = 1; end
            ST_ADDR:      begin asa = 1; asb = 2'd2; end
            ST_MEM_RD:    begin req = 1; rd = 1; iod = 1; end
            ST_WB_MEM:    begin rw = 1; m2r = 1; end
            ST_MEM_WR:    begin req = 1; wr = 1; iod = 1; r2l = 1; end
            ST_BRANCH_CB: begin asa = 1; aop = 2'd1; pcc = 1; ps = 2'd1; end
            ST_BRANCH_U:  begin pcw = 1; ps = 2'd2; end
            default:      ;
        endcase
        return {req, rd, wr, iod, irw, pcw, pcc, ps, asa, asb, aop, r2l, rw, m2r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance the model
    task automatic cycle(input logic rst, input logic rdy, input logic z);
        int     cls;
        state_t st;
        @(negedge clk);
        reset = rst; mem_ready = rdy; zero = z; opcode = cur_op;
        #1;
        cls = classify(cur_op);
        st  = step_of(cls, m_idx);
        if (rst) begin
            chk("ctrl", {47'd0, dut_vec}, 64'd0);
            chk("state", {60'd0, state}, 64'd0);
            chk("retired", {32'd0, retired}, 64'd0);
            chk("illegal", {63'd0, illegal}, 64'd0);
            m_idx = 0; m_ret = '0; m_ill = 1'b0;
        end else begin
            chk("ctrl", {47'd0, dut_vec}, {47'd0, exp_out(st, cls, rdy)});
            chk("state", {60'd0, state}, {60'd0, st});
            chk("retired", {32'd0, retired}, {32'd0, m_ret});
            chk("illegal", {63'd0, illegal}, {63'd0, m_ill});
            if (st == ST_TRAP) begin
                m_idx = m_idx;
            end else if ((st == ST_FETCH || st == ST_MEM_RD || st == ST_MEM_WR) && !rdy) begin
                m_idx = m_idx;
            end else if (m_idx == len_of(cls) - 1) begin
                m_idx = 0;
                m_ret = m_ret + 32'd1;
            end else begin
                m_idx = m_idx + 1;
                if (step_of(cls, m_idx) == ST_TRAP) m_ill = 1'b1;
            end
        end
        n_cyc++;
        if (n_cyc > 60000) begin
            $display("FAIL cycle_budget: got %0d cycles expected below 60000", n_cyc);
            $fatal(1);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction: fw fetch waits, mw waits in the data access
    task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                             input logic z, output int n);
        int     w;
        int     guard;
        logic   rdy;
        state_t st;
        cur_op = op; n = 0; w = mw; guard = 0;
        for (int i = 0; i < fw; i++) begin cycle(1'b0, 1'b0, z); n++; end
        cycle(1'b0, 1'b1, z); n++;
        while (m_idx != 0 && guard < 40) begin
            st = step_of(classify(op), m_idx);
            if (st == ST_TRAP) break;
            if (st == ST_MEM_RD || st == ST_MEM_WR) begin
                rdy = (w == 0);
                if (w > 0) w--;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            cycle(1'b0, rdy, z); n++; guard++;
        end
        if (guard >= 40) begin
            checks++; errors++;
            $display("FAIL instr_timeout: got %0d cycles expected completion", guard);
        end
    endtask

    logic [10:0] rtab [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

    initial begin
        int          n;
        logic [10:0] op;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // Reset while a load waits in MEM_RD
        cur_op = 11'b11111000010;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("mid_memrd_state", {60'd0, state}, {60'd0, ST_MEM_RD});
        chk("mid_memrd_req", {63'd0, mem_req}, 64'd1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rst_state", {60'd0, state}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_retired", {32'd0, retired}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);

        run_instr(11'b10001011000, 0, 0, 1'b0, n);
        settle();
        chk("add_cycles", n, 4);
        chk("add_retired", {32'd0, retired}, 64'd1);

        run_instr(11'b11111000010, 3, 2, 1'b0, n);
        settle();
        chk("ldur_cycles", n, 10);
        chk("ldur_retired", {32'd0, retired}, 64'd2);

        run_instr(11'b10110100101, 0, 0, 1'b1, n);
        settle();
        chk("cbz_z1_cycles", n, 3);
        chk("cbz_z1_retired", {32'd0, retired}, 64'd3);
        run_instr(11'b10110100010, 0, 0, 1'b0, n);
        settle();
        chk("cbz_z0_cycles", n, 3);
        chk("cbz_z0_retired", {32'd0, retired}, 64'd4);

        run_instr(11'b11111000000, 0, 0, 1'b0, n);
        settle();
        chk("stur_cycles", n, 4);
        chk("stur_retired", {32'd0, retired}, 64'd5);

        // Illegal opcode parks in TRAP regardless of mem_ready
        cur_op = 11'b11111111111;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 2), 1'(i % 3 == 0));
        settle();
        chk("trap_illegal", {63'd0, illegal}, 64'd1);
        chk("trap_state", {60'd0, state}, {60'd0, ST_TRAP});
        chk("trap_retired", {32'd0, retired}, 64'd5);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("trap_cleared", {63'd0, illegal}, 64'd0);

        // Counter wrap through a preloaded all-ones value
        cur_op = 11'b00010100000;
        cycle(1'b0, 1'b0, 1'b0);
        settle();
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        m_ret = 32'hFFFF_FFFF;
        run_instr(11'b00010100000, 0, 0, 1'b0, n);
        settle();
        chk("b_cycles", n, 3);
        chk("wrap_retired", {32'd0, retired}, 64'd0);

        // Randomized instruction mix with random memory latency
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0, 1:    op = rtab[$urandom_range(0, 3)];
                2:       op = 11'b11111000010;
                3:       op = 11'b11111000000;
                4:       op = {8'b10110100, 3'($urandom_range(0, 7))};
                5:       op = {6'b000101, 5'($urandom_range(0, 31))};
                default: op = 11'($urandom_range(0, 2047));
            endcase
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), n);
            if (m_ill) begin
                for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
